xnor_popcount_act: RTL and testbench
====================================

// Module: xnor_popcount_act
// PURPOSE
//  Downstream end of the binary-MAC datapath: consumes the 7-bit XNOR match vectors produced by the
//  bitwise XNOR stage and reduces them to a neuron result. Popcounts each beat, accumulates NBEATS
//  beats (one kernel window), and emits the bipolar dot product plus the binarized activation.
//  Sits between the XNOR array and the activation buffer; valid/ready on both sides.
// PARAMETERS
//  WIDTH   7                          match bits per beat (XNOR vector width)
//  NBEATS  7                          beats per window (7x7 kernel = 7 beats)
//  ACC_W   $clog2(WIDTH*NBEATS+1)     accumulator width (6 for defaults, max count 49)
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst_n      in   1          asynchronous active-low reset
//  flush      in   1          synchronous abort of current window, drops partial sum
//  in_valid   in   1          xnor_in beat valid
//  in_ready   out  1          block can accept a beat
//  xnor_in    in   WIDTH      match vector, bit=1 means img==wgt
//  thr        in   ACC_W      activation threshold (popcount units), sampled on first beat
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  pop_out    out  ACC_W      total matches in window (unsigned)
//  sum_out    out  ACC_W+1    bipolar dot product, signed = 2*pop_out - WIDTH*NBEATS
//  act_out    out  1          1 when pop_out >= thr_latched, else 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ACC, beat_cnt=0, acc=0, thr_q=0, out_valid=0, pop_out=0,
//   sum_out=0, act_out=0; in_ready=1 after release.
//  States: ACC (accepting beats), OUT (holding result).
//  in_ready = (state==ACC). Beat accepted on in_valid & in_ready.
//  ACC: on accept, acc += popcount(xnor_in) (zero-extended to ACC_W), beat_cnt++; on beat_cnt==0
//   accept, thr_q <= thr. On accept with beat_cnt==NBEATS-1: pop_out <= acc+pc, sum_out <=
//   2*(acc+pc)-WIDTH*NBEATS, act_out <= (acc+pc >= thr_eff) where thr_eff = thr if NBEATS==1
//   else thr_q; out_valid<=1, acc<=0, beat_cnt<=0, state->OUT.
//  Latency: result registered; out_valid rises the cycle after the last beat is accepted.
//  OUT: outputs held stable while out_valid & !out_ready. On out_ready: out_valid<=0, state->ACC;
//   next beat may be accepted the following cycle (no same-cycle bypass; 1 bubble per window).
//  Back-to-back windows: max throughput NBEATS beats per NBEATS+1 cycles.
//  flush: highest priority after reset. In ACC: acc<=0, beat_cnt<=0, beat presented that cycle is
//   dropped (in_ready still 1, but not counted). In OUT: out_valid<=0, state->ACC, result discarded.
//  Arithmetic: no overflow possible by ACC_W sizing; sum_out two's complement, range
//   [-WIDTH*NBEATS, +WIDTH*NBEATS]. thr > WIDTH*NBEATS gives act_out=0; thr=0 gives act_out=1.
//  xnor_in ignored when not accepted; X on xnor_in when in_valid=0 must not propagate.
//  Reset asserted mid-window: partial accumulation lost, next window starts from beat 0.
// TESTING
//  1 all-ones: 7 beats xnor_in=7'h7F, thr=25 -> pop_out=49, sum_out=+49, act_out=1, out_valid
//    one cycle after beat 7.
//  2 all-zeros: 7 beats 7'h00, thr=1 -> pop_out=0, sum_out=-49 (7'h4F), act_out=0.
//  3 threshold edge: 7 beats 7'b1010101 -> pop_out=28, sum_out=+7; thr=28 -> act_out=1;
//    repeat with thr=29 -> act_out=0; thr changed after beat 1 has no effect.
//  4 backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable;
//    out_ready=1 -> out_valid drops next cycle, next window's 7 beats accumulate independently.
//  5 flush/reset mid-window: 3 beats of 7'h7F, flush=1 one cycle, then 7 beats 7'h01 ->
//    pop_out=7, sum_out=-35; same with rst_n pulse instead of flush -> identical result.
//  6 gapped input: in_valid toggled randomly across 7 beats of 7'h0F -> pop_out=28, exactly one
//    out_valid per window, beat count unaffected by idle cycles.

Source files
------------

// File: rtl/xnor_popcount_act.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// xnor_popcount_act
//
// Reduction end of the binary-MAC datapath. Each accepted beat is a WIDTH-bit
// XNOR match vector (bit=1 means image bit equals weight bit). The block
// popcounts every beat, accumulates NBEATS beats (one kernel window) and then
// presents the window result until the consumer takes it:
//   pop_out : number of matching bits in the window (unsigned)
//   sum_out : bipolar dot product, 2*pop_out - WIDTH*NBEATS (two's complement)
//   act_out : binarized activation, pop_out >= threshold sampled on beat 0
//
// Ports
//   clk        in   1         clock, all state updates on the rising edge
//   rst_n      in   1         asynchronous active-low reset
//   flush      in   1         synchronous abort: drops the partial window or
//                             the pending result
//   in_valid   in   1         xnor_in carries a beat
//   in_ready   out  1         block can accept a beat (high while accumulating)
//   xnor_in    in   WIDTH     match vector
//   thr        in   ACC_W     activation threshold, sampled with the first beat
//   out_valid  out  1         window result valid
//   out_ready  in   1         consumer takes the result
//   pop_out    out  ACC_W     window match count
//   sum_out    out  ACC_W+1   bipolar dot product (signed)
//   act_out    out  1         activation bit
//
// Throughput: the result register is not bypassed, so a window of NBEATS
// beats occupies at least NBEATS+1 cycles (one bubble while the result is
// handed off).
// -----------------------------------------------------------------------------
module xnor_popcount_act #(
    parameter int WIDTH  = 7,
    parameter int NBEATS = 7,
    parameter int ACC_W  = $clog2(WIDTH * NBEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] xnor_in,
    input  logic [ACC_W-1:0] thr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] pop_out,
    output logic [ACC_W:0]   sum_out,
    output logic             act_out
);

    localparam int TOTAL = WIDTH * NBEATS;
    // Keep the beat counter at least one bit wide so NBEATS==1 still elaborates.
    localparam int CNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    typedef enum logic {
        ST_ACC = 1'b0,   // accepting beats of the current window
        ST_OUT = 1'b1    // holding a finished result for the consumer
    } state_e;

    // Ones count of one beat, already widened to the accumulator width.
    function automatic logic [ACC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [ACC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + ACC_W'(v[i]);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q;
    logic [CNT_W-1:0] beat_cnt_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] thr_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] pop_q;
    logic [ACC_W:0]   sum_q;
    logic             act_q;

    // -------------------------------------------------------------------------
    // Beat-path arithmetic
    // -------------------------------------------------------------------------
    logic             accept;
    logic             first_beat;
    logic             last_beat;
    logic [ACC_W-1:0] beat_pc;
    logic [ACC_W-1:0] total_d;
    logic [ACC_W-1:0] thr_eff;
    logic [ACC_W:0]   sum_d;
    logic             act_d;

    assign in_ready = (state_q == ST_ACC);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every output of this block is assigned before any branch, so
        // no path leaves a value unassigned and no latch can be inferred.
        first_beat = (beat_cnt_q == '0);
        last_beat  = (beat_cnt_q == CNT_W'(NBEATS - 1));
        // Gate the vector with accept so an undriven xnor_in between beats
        // never reaches the adder.
        beat_pc    = popcount(accept ? xnor_in : '0);
        total_d    = acc_q + beat_pc;
        // With a single-beat window the threshold register has not been loaded
        // yet on the completing beat, so the live input is the right one.
        thr_eff    = (NBEATS == 1) ? thr : thr_q;
        // 2*total - TOTAL evaluated modulo 2^(ACC_W+1); the true value lies in
        // [-TOTAL, +TOTAL], which that width represents exactly.
        sum_d      = {total_d, 1'b0} - (ACC_W + 1)'(TOTAL);
        act_d      = (total_d >= thr_eff);
    end

    // -------------------------------------------------------------------------
    // Window FSM with registered result outputs
    // -------------------------------------------------------------------------
    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            thr_q       <= '0;
            out_valid_q <= 1'b0;
            pop_q       <= '0;
            sum_q       <= '0;
            act_q       <= 1'b0;
        end else if (flush) begin
            // Abort in either state: partial sum and pending result are lost,
            // the beat presented this cycle is not counted.
            state_q     <= ST_ACC;
            beat_cnt_q  <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (accept) begin
                        if (first_beat) begin
                            thr_q <= thr;
                        end
                        if (last_beat) begin
                            pop_q       <= total_d;
                            sum_q       <= sum_d;
                            act_q       <= act_d;
                            out_valid_q <= 1'b1;
                            acc_q       <= '0;
                            beat_cnt_q  <= '0;
                            state_q     <= ST_OUT;
                        end else begin
                            acc_q      <= total_d;
                            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    // Result registers are untouched here, so they stay stable
                    // for as long as the consumer stalls.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign pop_out   = pop_q;
    assign sum_out   = sum_q;
    assign act_out   = act_q;

endmodule

// File: tb/tb_xnor_popcount_act.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_xnor_popcount_act
//
// Self-checking bench. Inputs are driven 1 ns after the rising edge and
// outputs are sampled at that same point, well away from the active edge.
// Expected window results come from a plain-arithmetic model: count the ones
// in all beats of the window, derive the bipolar sum and compare against the
// threshold that accompanied the first beat.
// -----------------------------------------------------------------------------
module tb_xnor_popcount_act;

    localparam int WIDTH  = 7;
    localparam int NBEATS = 7;
    localparam int ACC_W  = 6;
    localparam int TOTAL  = WIDTH * NBEATS;
    localparam int BOUND  = 64;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             flush     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] xnor_in   = '0;
    logic [ACC_W-1:0] thr       = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] pop_out;
    logic [ACC_W:0]   sum_out;
    logic             act_out;

    int n_cmp  = 0;
    int n_err  = 0;
    int hs_cnt = 0;

    xnor_popcount_act #(
        .WIDTH (WIDTH),
        .NBEATS(NBEATS),
        .ACC_W (ACC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .xnor_in  (xnor_in),
        .thr      (thr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pop_out  (pop_out),
        .sum_out  (sum_out),
        .act_out  (act_out)
    );

    always #5 clk = ~clk;

    // Completed result handshakes, used to prove one result per window.
    always @(posedge clk) begin
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;
    end

    // ---------------------------------------------------------------- model
    function automatic int model_pop(input logic [WIDTH-1:0] b[NBEATS]);
        int p = 0;
        for (int i = 0; i < NBEATS; i++) p += $countones(b[i]);
        return p;
    endfunction

    function automatic int model_sum(input int pop);
        return 2 * pop - TOTAL;
    endfunction

    function automatic bit model_act(input int pop, input int t);
        return pop >= t;
    endfunction

    // ------------------------------------------------------------- drivers
    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Present one beat until accepted; optional random idle cycles first.
    task automatic drive_beat(input logic [WIDTH-1:0] x, input logic [ACC_W-1:0] t,
                              input bit gaps, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                in_valid = 1'b0;
                xnor_in  = 'x;
                thr      = ACC_W'($urandom);
                @(posedge clk); #1;
            end else begin
                in_valid = 1'b1;
                xnor_in  = x;
                thr      = t;
                if (in_ready === 1'b1) begin
                    @(posedge clk); #1;
                    in_valid = 1'b0;
                    xnor_in  = 'x;
                    ok = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic run_window(input logic [WIDTH-1:0] b[NBEATS], input logic [ACC_W-1:0] t_first,
                              input logic [ACC_W-1:0] t_rest, input bit gaps, output bit ok);
        bit one;
        ok = 1'b1;
        for (int i = 0; i < NBEATS; i++) begin
            drive_beat(b[i], (i == 0) ? t_first : t_rest, gaps, one);
            ok &= one;
        end
    endtask

    // Wait (bounded) for a result, capture it, then hand it off in one cycle.
    task automatic get_result(output bit got, output int pop, output int sum, output bit act);
        got = 1'b0; pop = -1; sum = -1000; act = 1'b0;
        for (int c = 0; c < BOUND; c++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (got) begin
            pop = int'(pop_out);
            sum = $signed(sum_out);
            act = act_out;
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic fill(output logic [WIDTH-1:0] b[NBEATS], input logic [WIDTH-1:0] v);
        for (int i = 0; i < NBEATS; i++) b[i] = v;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (pop_out !== '0) begin n_err++; $display("FAIL reset_pop: got %0d want 0", pop_out); end
        n_cmp++; if (sum_out !== '0) begin n_err++; $display("FAIL reset_sum: got %0d want 0", sum_out); end
        n_cmp++; if (act_out !== 1'b0) begin n_err++; $display("FAIL reset_act: got %b want 0", act_out); end
    endtask

    task automatic test_all_ones();
        bit ok, all_ok, got, act;
        int pop, sum;
        all_ok = 1'b1;
        for (int i = 0; i < NBEATS - 1; i++) begin
            drive_beat(7'h7F, 6'd25, 1'b0, ok);
            all_ok &= ok;
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ones_early_valid: got %b want 0", out_valid); end
        drive_beat(7'h7F, 6'd25, 1'b0, ok);
        all_ok &= ok;
        n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL ones_accept: got %b want 1", all_ok); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ones_latency: got %b want 1", out_valid); end
        get_result(got, pop, sum, act);
        n_cmp++; if (got !== 1'b1) begin n_err++; $display("FAIL ones_result_timeout: got %b want 1", got); end
        n_cmp++; if (pop !== 49) begin n_err++; $display("FAIL ones_pop: got %0d want 49", pop); end
        n_cmp++; if (sum !== 49) begin n_err++; $display("FAIL ones_sum: got %0d want 49", sum); end
        n_cmp++; if (act !== 1'b1) begin n_err++; $display("FAIL ones_act: got %b want 1", act); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ones_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_all_zeros();
        logic [WIDTH-1:0] b[NBEATS];
        bit ok, got, act;
        int pop, sum;
        fill(b, 7'h00);
        run_window(b, 6'd1, 6'd1, 1'b0, ok);
        get_result(got, pop, sum, act);
        n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL zeros_handshake: got %b/%b want 1/1", ok, got); end
        n_cmp++; if (pop !== 0) begin n_err++; $display("FAIL zeros_pop: got %0d want 0", pop); end
        n_cmp++; if (sum !== -49) begin n_err++; $display("FAIL zeros_sum: got %0d want -49", sum); end
        n_cmp++; if (act !== 1'b0) begin n_err++; $display("FAIL zeros_act: got %b want 0", act); end
    endtask

    task automatic test_threshold_edge();
        logic [WIDTH-1:0] b[NBEATS];
        logic [ACC_W-1:0] t_first[4] = '{6'd28, 6'd29, 6'd28, 6'd29};
        logic [ACC_W-1:0] t_rest[4]  = '{6'd28, 6'd29, 6'd63, 6'd0};
        bit ok, got, act;
        int pop, sum;
        fill(b, 7'b1010101);
        for (int k = 0; k < 4; k++) begin
            run_window(b, t_first[k], t_rest[k], 1'b0, ok);
            get_result(got, pop, sum, act);
            n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL thr_handshake[%0d]: got %b/%b want 1/1", k, ok, got); end
            n_cmp++; if (pop !== 28) begin n_err++; $display("FAIL thr_pop[%0d]: got %0d want 28", k, pop); end
            n_cmp++; if (sum !== 7) begin n_err++; $display("FAIL thr_sum[%0d]: got %0d want 7", k, sum); end
            n_cmp++; if (act !== model_act(28, int'(t_first[k]))) begin
                n_err++; $display("FAIL thr_act[%0d]: got %b want %b (thr %0d)", k, act, model_act(28, int'(t_first[k])), t_first[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] b[NBEATS];
        logic [ACC_W-1:0] t;
        bit ok, got, act;
        int pop, sum, ep, es;
        bit ea;
        for (int i = 0; i < NBEATS; i++) b[i] = WIDTH'($urandom);
        t  = ACC_W'($urandom_range(0, 50));
        ep = model_pop(b); es = model_sum(ep); ea = model_act(ep, int'(t));
        run_window(b, t, t, 1'b0, ok);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        xnor_in   = 7'h7F;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
            n_cmp++; if (int'(pop_out) !== ep || int'($signed(sum_out)) !== es || act_out !== ea) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %0d/%0d/%b want %0d/%0d/%b", c, pop_out, $signed(sum_out), act_out, ep, es, ea);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        // Next window must not contain the beat held during the stall.
        for (int i = 0; i < NBEATS; i++) b[i] = WIDTH'($urandom);
        t  = ACC_W'($urandom_range(0, 50));
        ep = model_pop(b); es = model_sum(ep); ea = model_act(ep, int'(t));
        run_window(b, t, ~t, 1'b1, ok);
        get_result(got, pop, sum, act);
        n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL bp_next_handshake: got %b/%b want 1/1", ok, got); end
        n_cmp++; if (pop !== ep || sum !== es || act !== ea) begin
            n_err++; $display("FAIL bp_next_result: got %0d/%0d/%b want %0d/%0d/%b", pop, sum, act, ep, es, ea);
        end
    endtask

    // Abort mid-window either by flush or by an asynchronous reset pulse.
    task automatic test_abort(input bit use_reset);
        logic [WIDTH-1:0] b[NBEATS];
        bit ok, got, act;
        int pop, sum;
        for (int i = 0; i < 3; i++) drive_beat(7'h7F, 6'd0, 1'b0, ok);
        if (use_reset) begin
            rst_n = 1'b0;
            #2;
            n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_mid_async: got ready %b valid %b want 1 0", in_ready, out_valid);
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            flush    = 1'b1;
            in_valid = 1'b1;
            xnor_in  = 7'h7F;
            @(posedge clk); #1;
            flush    = 1'b0;
            in_valid = 1'b0;
        end
        fill(b, 7'h01);
        run_window(b, 6'd7, 6'd8, 1'b0, ok);
        get_result(got, pop, sum, act);
        n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL abort%0d_handshake: got %b/%b want 1/1", use_reset, ok, got); end
        n_cmp++; if (pop !== 7) begin n_err++; $display("FAIL abort%0d_pop: got %0d want 7", use_reset, pop); end
        n_cmp++; if (sum !== -35) begin n_err++; $display("FAIL abort%0d_sum: got %0d want -35", use_reset, sum); end
        n_cmp++; if (act !== 1'b1) begin n_err++; $display("FAIL abort%0d_act: got %b want 1", use_reset, act); end
    endtask

    task automatic test_flush_out();
        logic [WIDTH-1:0] b[NBEATS];
        bit ok, got, act;
        int pop, sum, h0, ep;
        fill(b, 7'h7F);
        run_window(b, 6'd0, 6'd0, 1'b0, ok);
        h0 = hs_cnt;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_out_ready: got %b want 1", in_ready); end
        for (int i = 0; i < NBEATS; i++) b[i] = WIDTH'($urandom);
        ep = model_pop(b);
        run_window(b, 6'd63, 6'd0, 1'b0, ok);
        get_result(got, pop, sum, act);
        n_cmp++; if (hs_cnt - h0 !== 1) begin n_err++; $display("FAIL flush_out_handshakes: got %0d want 1", hs_cnt - h0); end
        n_cmp++; if (pop !== ep || sum !== model_sum(ep) || act !== 1'b0) begin
            n_err++; $display("FAIL flush_out_next: got %0d/%0d/%b want %0d/%0d/0", pop, sum, act, ep, model_sum(ep));
        end
    endtask

    task automatic test_gapped();
        logic [WIDTH-1:0] b[NBEATS];
        bit ok, got, act;
        int pop, sum, h0;
        h0 = hs_cnt;
        fill(b, 7'h0F);
        run_window(b, 6'd28, 6'd29, 1'b1, ok);
        get_result(got, pop, sum, act);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL gap_handshake: got %b/%b want 1/1", ok, got); end
        n_cmp++; if (pop !== 28 || sum !== 7 || act !== 1'b1) begin
            n_err++; $display("FAIL gap_result: got %0d/%0d/%b want 28/7/1", pop, sum, act);
        end
        n_cmp++; if (hs_cnt - h0 !== 1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL gap_one_result: got %0d results, valid %b want 1, 0", hs_cnt - h0, out_valid);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] b[NBEATS];
        logic [ACC_W-1:0] t;
        logic [ACC_W-1:0] corner[4] = '{6'd0, 6'd49, 6'd50, 6'd63};
        bit ok, got, act, ea;
        int pop, sum, ep;
        for (int w = 0; w < 24; w++) begin
            for (int i = 0; i < NBEATS; i++) b[i] = WIDTH'($urandom);
            if (w % 6 == 0) b = '{default: 7'h7F};
            t  = (w < 4) ? corner[w] : ACC_W'($urandom_range(15, 35));
            ep = model_pop(b);
            ea = model_act(ep, int'(t));
            run_window(b, t, ACC_W'($urandom), ($urandom_range(0, 1) == 1), ok);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            get_result(got, pop, sum, act);
            n_cmp++; if (got !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL rand_handshake[%0d]: got %b/%b want 1/1", w, ok, got); end
            n_cmp++; if (pop !== ep || sum !== model_sum(ep) || act !== ea) begin
                n_err++; $display("FAIL rand_result[%0d]: got %0d/%0d/%b want %0d/%0d/%b (thr %0d)",
                                  w, pop, sum, act, ep, model_sum(ep), ea, t);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_ones();
        test_all_zeros();
        test_threshold_edge();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_out();
        test_gapped();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
